iir_mac_sched: RTL and testbench

Time-multiplexed controller for the second-order IIR section y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2. One shared multiplier-accumulator is sequenced over the five taps, so each sample takes five MAC cycles instead of five parallel multipliers. The block sits between a valid/ready sample source and sink, owns the x1/x2/y1/y2 history, and exposes a coefficient register file so the filter can be retuned at run time.

---
 rtl/iir_pkg.sv | 27 ++
 rtl/iir_mac.sv | 77 +++++++
 rtl/iir_mac_sched.sv | 146 ++++++++++++++
 tb/tb_iir_mac_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// iir_pkg: shared types and constants for the iir_mac_sched biquad controller.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Tap index: 0=b0*x, 1=b1*x1, 2=b2*x2, 3=-a1*y1, 4=-a2*y2
  typedef logic [2:0] tap_t;

  localparam tap_t LAST_TAP = 3'd4;

  localparam logic [2:0] CFG_B0 = 3'd0;
  localparam logic [2:0] CFG_B1 = 3'd1;
  localparam logic [2:0] CFG_B2 = 3'd2;
  localparam logic [2:0] CFG_A1 = 3'd3;
  localparam logic [2:0] CFG_A2 = 3'd4;

  localparam int B0_DEF = 6;
  localparam int B1_DEF = 1;
  localparam int B2_DEF = 2;
  localparam int A1_DEF = 4;
  localparam int A2_DEF = 3;

endpackage

// File: rtl/iir_mac.sv
// iir_mac: shared signed multiply-accumulate, one product per enabled cycle.
// Build option IIR_SAT_EN: widen the accumulator to 2*DATA_W+3 bits and
// saturate the result to the DATA_W signed range; otherwise wrap mod 2^DATA_W.
module iir_mac #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              sub,
  input  logic [DATA_W-1:0] coef,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

`ifdef IIR_SAT_EN
  localparam int ACC_W = 2 * DATA_W + 3;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;

  // Full-precision signed product: the low 2*DATA_W bits of the product of
  // sign-extended operands are exact, then sign-extend into the accumulator.
  always_comb begin
    prod     = {{DATA_W{coef[DATA_W-1]}}, coef} * {{DATA_W{data[DATA_W-1]}}, data};
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end
`else
  localparam int ACC_W = DATA_W;

  logic [DATA_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;

  // Truncated product: two's complement wrap makes signedness irrelevant here.
  always_comb begin
    prod     = coef * data;
    prod_ext = prod;
  end
`endif

  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Next accumulator: clear on sample accept, add/subtract one product per tap.
  always_comb begin
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = sub ? (acc_q - $signed(prod_ext)) : (acc_q + $signed(prod_ext));
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

`ifdef IIR_SAT_EN
  // Clamp the wide accumulator into the DATA_W signed range.
  always_comb begin
    result = acc_q[DATA_W-1:0];
    if (acc_q > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
    else if (acc_q < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
  end
`else
  // Accumulator already holds the wrapped result.
  always_comb begin
    result = acc_q;
  end
`endif

endmodule

// File: rtl/iir_mac_sched.sv
// iir_mac_sched: time-multiplexed biquad controller. One MAC is stepped over
// the five taps per sample; owns coefficient file, history and handshakes.
// Build option IIR_SAT_EN selects a saturating result (see iir_mac).
module iir_mac_sched
  import iir_pkg::*;
#(
  parameter int                       DATA_W  = 32,
  parameter logic signed [DATA_W-1:0] B0_INIT = DATA_W'(B0_DEF),
  parameter logic signed [DATA_W-1:0] B1_INIT = DATA_W'(B1_DEF),
  parameter logic signed [DATA_W-1:0] B2_INIT = DATA_W'(B2_DEF),
  parameter logic signed [DATA_W-1:0] A1_INIT = DATA_W'(A1_DEF),
  parameter logic signed [DATA_W-1:0] A2_INIT = DATA_W'(A2_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              busy
);

  state_e            state_q, state_d;
  tap_t              tap_q, tap_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [DATA_W-1:0] y1_q, y1_d, y2_q, y2_d;
  logic [DATA_W-1:0] coef_q [5];
  logic [DATA_W-1:0] coef_d [5];

  logic              accept;
  logic              mac_en, mac_sub;
  logic [DATA_W-1:0] mac_coef, mac_data, mac_y;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign mac_en    = (state_q == MAC);
  assign out_data  = mac_y;

  // FSM next state, tap sequencing, history shift and coefficient writes.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    x_d     = x_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    coef_d  = coef_q;
    unique case (state_q)
      IDLE: begin
        // Write lands at the accept edge so the new sample sees it.
        if (cfg_we) begin
          case (cfg_addr)
            CFG_B0:  coef_d[0] = cfg_data;
            CFG_B1:  coef_d[1] = cfg_data;
            CFG_B2:  coef_d[2] = cfg_data;
            CFG_A1:  coef_d[3] = cfg_data;
            CFG_A2:  coef_d[4] = cfg_data;
            default: ;
          endcase
        end
        if (accept) begin
          x_d     = in_data;
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        tap_d = tap_q + 3'd1;
        if (tap_q == LAST_TAP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          x2_d    = x1_q;
          x1_d    = x_q;
          y2_d    = y1_q;
          y1_d    = mac_y;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the current tap's coefficient and history operand to the MAC.
  always_comb begin
    mac_coef = '0;
    mac_data = '0;
    mac_sub  = 1'b0;
    case (tap_q)
      3'd0: begin mac_coef = coef_q[0]; mac_data = x_q;  end
      3'd1: begin mac_coef = coef_q[1]; mac_data = x1_q; end
      3'd2: begin mac_coef = coef_q[2]; mac_data = x2_q; end
      3'd3: begin mac_coef = coef_q[3]; mac_data = y1_q; mac_sub = 1'b1; end
      3'd4: begin mac_coef = coef_q[4]; mac_data = y2_q; mac_sub = 1'b1; end
      default: ;
    endcase
  end

  // State, history and coefficient registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      x_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      coef_q[0] <= B0_INIT;
      coef_q[1] <= B1_INIT;
      coef_q[2] <= B2_INIT;
      coef_q[3] <= A1_INIT;
      coef_q[4] <= A2_INIT;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      coef_q  <= coef_d;
    end
  end

  iir_mac #(.DATA_W(DATA_W)) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (mac_en),
    .sub    (mac_sub),
    .coef   (mac_coef),
    .data   (mac_data),
    .result (mac_y)
  );

endmodule

// File: tb/tb_iir_mac_sched.sv
// Directed bench for iir_mac_sched; expected values are hand-computed.
// Compile with IIR_SAT_EN defined to select the saturating expectation.
module tb_iir_mac_sched;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              busy;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  iir_mac_sched dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy)
  );

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [DATA_W-1:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Offer x from IDLE; cfg_at: 0 none, 1 with the accept, 2 in first MAC cycle.
  // lat = edges after accept until out_valid seen (-1 on timeout).
  // Completes the output handshake when out_ready is high.
  task automatic run_sample(input logic [DATA_W-1:0] x, input int cfg_at,
                            input logic [2:0] ca, input logic [DATA_W-1:0] cv,
                            output logic [DATA_W-1:0] y, output int lat);
    lat = -1; y = 'x;
    in_valid = 1'b1; in_data = x;
    if (cfg_at == 1) begin cfg_we = 1'b1; cfg_addr = ca; cfg_data = cv; end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    if (cfg_at == 2) begin cfg_we = 1'b1; cfg_addr = ca; cfg_data = cv; end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (out_valid) begin lat = n; y = out_data; break; end
    end
    if (lat > 0 && out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] xs [3];
    logic [DATA_W-1:0] ys [3];
    logic [DATA_W-1:0] y;
    int lat;
    xs[0] = 1; xs[1] = 0; xs[2] = 0;
    ys[0] = 32'd6; ys[1] = -32'sd23; ys[2] = 32'd76;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_sample(xs[i], 0, 3'd0, '0, y, lat);
      // lat==5 edges after the accept edge T means out_valid in cycle T+6
      vecs++; if (lat !== 5) begin errs++; $display("FAIL basic_latency[%0d] got %0d want 5", i, lat); end
      vecs++; if (y !== ys[i]) begin errs++; $display("FAIL basic_y[%0d] got %0d want %0d", i, $signed(y), $signed(ys[i])); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL basic_idle[%0d] in_ready got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] y;
    int lat;
    do_reset();
    out_ready = 1'b0;
    run_sample(32'd1, 0, 3'd0, '0, y, lat);
    vecs++; if (y !== 32'd6) begin errs++; $display("FAIL bp_y got %0d want 6", $signed(y)); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (out_data !== 32'd6 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
        errs++;
        $display("FAIL bp_hold[%0d] got data=%0d rdy=%b vld=%b busy=%b want 6/0/1/1",
                 i, $signed(out_data), in_ready, out_valid, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    run_sample(32'd0, 0, 3'd0, '0, y, lat);
    vecs++; if (y !== -32'sd23) begin errs++; $display("FAIL bp_next_y got %0d want -23", $signed(y)); end
  endtask

  task automatic test_cfg();
    logic [DATA_W-1:0] y;
    int lat;
    do_reset();
    cfg_write(3'd0, 32'd10);
    run_sample(32'd2, 0, 3'd0, '0, y, lat);
    vecs++; if (y !== 32'd20) begin errs++; $display("FAIL cfg_b0_y got %0d want 20", $signed(y)); end
    // 10*1 + 1*2 - 4*20 = -68; the b0=99 write during MAC must be dropped
    run_sample(32'd1, 2, 3'd0, 32'd99, y, lat);
    vecs++; if (y !== -32'sd68) begin errs++; $display("FAIL cfg_mac_y got %0d want -68", $signed(y)); end
    // 10*1 + 1*1 + 2*2 + 4*68 - 3*20 = 227 (316 if b0 were 99)
    run_sample(32'd1, 0, 3'd0, '0, y, lat);
    vecs++; if (y !== 32'd227) begin errs++; $display("FAIL cfg_dropped_y got %0d want 227", $signed(y)); end
  endtask

  task automatic test_reset_mid_mac();
    logic [DATA_W-1:0] y;
    int lat;
    int seen;
    do_reset();
    in_valid = 1'b1; in_data = 32'd5;
    @(posedge clk); #1;           // accept
    in_valid = 1'b0;
    @(posedge clk); #1;           // tap0 done
    @(posedge clk); #1;           // tap1 done, tap 2 is now in flight
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL rst_mid_out_valid got %0d cycles want 0", seen); end
    run_sample(32'd1, 0, 3'd0, '0, y, lat);
    vecs++; if (y !== 32'd6) begin errs++; $display("FAIL rst_mid_next_y got %0d want 6", $signed(y)); end
  endtask

  task automatic test_sat();
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] exp_y;
    int lat;
`ifdef IIR_SAT_EN
    exp_y = 32'h7FFF_FFFF;
`else
    exp_y = 32'hFFFF_FFFE;
`endif
    do_reset();
    cfg_write(3'd3, 32'd0);
    cfg_write(3'd4, 32'd0);
    cfg_write(3'd0, 32'h7FFF_FFFF);
    run_sample(32'd2, 0, 3'd0, '0, y, lat);
    vecs++; if (y !== exp_y) begin errs++; $display("FAIL sat_y got %08h want %08h", y, exp_y); end
  endtask

  task automatic test_same_cycle_cfg();
    logic [DATA_W-1:0] y;
    int lat;
    do_reset();
    run_sample(32'd4, 1, 3'd0, 32'd3, y, lat);
    vecs++; if (y !== 32'd12) begin errs++; $display("FAIL same_cycle_y got %0d want 12", $signed(y)); end
    vecs++; if (lat !== 5) begin errs++; $display("FAIL same_cycle_latency got %0d want 5", lat); end
  endtask

  // Never-both invariant checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (reset === 1'b0 && in_ready === 1'b1 && out_valid === 1'b1) begin
      errs++;
      $display("FAIL ready_valid_overlap got both 1 want exclusive");
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg();
    test_reset_mid_mac();
    test_sat();
    test_same_cycle_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
